// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state encoding, the NOP word and the default vectors.
// Also provides a small helper for the word-alignment test on fetch addresses.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FULL = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST       = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC0_0380;

    // True when a fetch address is not word aligned
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next fetch-PC selection: exception > ERET > branch/jump, else sequential.
// Purely combinational, zero latency.
// No flow control; the caller decides when the selected PC is applied.
module if_next_pc
    import if_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        except_i,
    input  logic        eret_en_i,
    input  logic        redirect_en_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] fetch_pc_i,
    output logic        redir_vld_o,
    output logic [31:0] redir_pc_o,
    output logic [31:0] seq_pc_o,
    output logic        misaligned_o
);

    // Priority mux over the redirect sources; sequential PC wraps modulo 2^32
    always_comb begin
        redir_vld_o = except_i | eret_en_i | redirect_en_i;
        redir_pc_o  = fetch_pc_i;
        if (except_i) begin
            redir_pc_o = EXC_VECTOR;
        end else if (eret_en_i) begin
            redir_pc_o = epc_i;
        end else if (redirect_en_i) begin
            redir_pc_o = redirect_pc_i;
        end
        seq_pc_o     = fetch_pc_i + 32'd4;
        misaligned_o = pc_misaligned(fetch_pc_i);
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, talks to imem over req/ack, presents {pc, inst, valid, adel}.
// Latency: one edge from ack to presented bundle; 1 instr/cycle with a zero-wait memory.
// Backpressure: write=0 freezes the bundle; a new request is only started when its result can be absorbed.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        except,
    input  logic        eret_en,
    input  logic [31:0] epc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out,
    output logic        adel_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic         req_pend_q, req_pend_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         valid_q, valid_d;
    logic         adel_q, adel_d;

    logic         redir_vld;
    logic [31:0]  redir_pc;
    logic [31:0]  seq_pc;
    logic         misaligned;
    logic         issue;
    logic         outstanding;
    logic         squash;

    if_next_pc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .except_i      (except),
        .eret_en_i     (eret_en),
        .redirect_en_i (redirect_en),
        .epc_i         (epc_in),
        .redirect_pc_i (redirect_pc),
        .fetch_pc_i    (fetch_pc_q),
        .redir_vld_o   (redir_vld),
        .redir_pc_o    (redir_pc),
        .seq_pc_o      (seq_pc),
        .misaligned_o  (misaligned)
    );

    // Request handshake. A request in REQ starts only if the bundle is empty or being
    // consumed at this edge; once started (req_pend_q) it is held until ack. Doing so
    // guarantees an ack never arrives while a stalled valid bundle occupies the register.
    // In DROP the original address is replayed so imem_addr stays stable until ack.
    always_comb begin
        issue       = (state_q == ST_REQ) && !misaligned && (req_pend_q || !valid_q || write);
        imem_req    = issue || (state_q == ST_DROP);
        imem_addr   = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
        outstanding = imem_req && !imem_ack;
        squash      = redir_vld || flush;
    end

    // Next-state: redirect/flush first, then per-state capture/consume behaviour
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        req_pend_d  = req_pend_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        adel_d      = adel_q;

        // Decode took the bundle: leave a bubble unless something refills it below
        if (write) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            adel_d  = 1'b0;
        end

        if (squash) begin
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            adel_d     = 1'b0;
            req_pend_d = 1'b0;
            if (redir_vld) begin
                fetch_pc_d = redir_pc;
            end
            if (outstanding) begin
                state_d     = ST_DROP;
                drop_addr_d = imem_addr;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (misaligned) begin
                        // Present the faulting PC without touching memory; wait for the redirect
                        if (!valid_q || write) begin
                            pc_d    = fetch_pc_q;
                            inst_d  = NOP_INST;
                            valid_d = 1'b1;
                            adel_d  = 1'b1;
                            state_d = ST_FULL;
                        end
                    end else if (issue && imem_ack) begin
                        pc_d       = fetch_pc_q;
                        inst_d     = imem_rdata;
                        valid_d    = 1'b1;
                        adel_d     = 1'b0;
                        fetch_pc_d = seq_pc;
                        req_pend_d = 1'b0;
                        state_d    = write ? ST_REQ : ST_FULL;
                    end else if (issue) begin
                        req_pend_d = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (write) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and bundle registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
            req_pend_q  <= 1'b0;
            pc_q        <= '0;
            inst_q      <= NOP_INST;
            valid_q     <= 1'b0;
            adel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            req_pend_q  <= req_pend_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            adel_q      <= adel_d;
        end
    end

    // Bundle outputs come straight from registers
    always_comb begin
        pc_out    = pc_q;
        inst_out  = inst_q;
        valid_out = valid_q;
        adel_out  = adel_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a memory with random ack latency, random stalls and redirects.
// Reference: the in-order program stream -- each accepted instruction must be the
// successor of the previous one (pc+4, or the redirect target), with inst = memory word.
module tb_if_stage;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        except;
    logic        eret_en;
    logic [31:0] epc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic        adel_out;

    if_stage #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .except      (except),
        .eret_en     (eret_en),
        .epc_in      (epc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .valid_out   (valid_out),
        .adel_out    (adel_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: PC the next accepted instruction must carry
    logic [31:0] exp_q[$];
    // Addresses of acknowledged memory requests, in order
    logic [31:0] ack_log[$];

    // Memory model state
    int  mem_cnt  = 0;
    int  mem_lat  = 0;
    int  lat_min  = 0;
    int  lat_max  = 0;
    bit  prev_req = 1'b0;
    bit  prev_ack = 1'b0;
    bit  mon_en   = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        int unsigned r;
        t = $urandom & 32'hFFFF_FFFC;
        r = $urandom_range(9, 0);
        if (r == 0) t = t | 32'($urandom_range(3, 1));
        else if (r == 1) t = 32'hFFFF_FFF4;
        return t;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: inputs change at negedge, memory answers 1ns later
    task automatic drive_cycle(input bit rnd);
        int unsigned r;
        @(negedge clk);
        if (prev_req && prev_ack) begin
            mem_cnt = 0;
            mem_lat = $urandom_range(lat_max, lat_min);
        end else if (prev_req) begin
            mem_cnt++;
        end
        write       = 1'b1;
        flush       = 1'b0;
        except      = 1'b0;
        eret_en     = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = rand_target();
        epc_in      = rand_target();
        if (rnd) begin
            write = ($urandom_range(3, 0) != 0);
            if ($urandom_range(99, 0) < 6) begin
                r = $urandom_range(3, 0);
                if (r == 0) begin
                    except      = 1'b1;
                    flush       = 1'b1;
                    redirect_en = 1'($urandom_range(1, 0));
                end else if (r == 1) begin
                    eret_en = 1'b1;
                    flush   = 1'b1;
                end else begin
                    redirect_en = 1'b1;
                end
            end
        end
        if (except || eret_en || redirect_en) begin
            exp_q.delete();
            exp_q.push_back(except ? EXC_VECTOR : (eret_en ? epc_in : redirect_pc));
        end
        #1;
        imem_ack   = imem_req && (mem_cnt >= mem_lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        if (imem_ack) ack_log.push_back(imem_addr);
        prev_req = imem_req;
        prev_ack = imem_ack;
    endtask

    // Monitor: invariants every cycle, and stream comparison on every accepted bundle
    logic [31:0] held_pc, held_inst, pend_addr, e;
    logic        held_adel;
    bit          hold_chk = 1'b0;
    bit          out_pend = 1'b0;
    int          idle_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                hold_chk = 1'b0;
                out_pend = 1'b0;
                idle_cyc = 0;
            end else begin
                if (!valid_out) begin
                    check32("bubble_inst", inst_out, 32'h0);
                    check32("bubble_adel", {31'h0, adel_out}, 32'h0);
                end
                if (imem_req) check32("req_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
                if (out_pend) begin
                    check32("req_held", {31'h0, imem_req}, 32'h1);
                    check32("addr_held", imem_addr, pend_addr);
                end
                if (hold_chk) begin
                    check32("stall_pc", pc_out, held_pc);
                    check32("stall_inst", inst_out, held_inst);
                    check32("stall_valid", {31'h0, valid_out}, 32'h1);
                    check32("stall_adel", {31'h0, adel_out}, {31'h0, held_adel});
                end
                if (valid_out && !write && !out_pend) begin
                    check32("no_new_req_in_stall", {31'h0, imem_req}, 32'h0);
                end
                if (write && valid_out && !(except || eret_en || redirect_en || flush)) begin
                    idle_cyc = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream: accepted pc %h with no expectation", pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        check32("stream_pc", pc_out, e);
                        if (e[1:0] != 2'b00) begin
                            check32("stream_adel", {31'h0, adel_out}, 32'h1);
                            check32("stream_inst", inst_out, 32'h0);
                            exp_q.push_back(e);
                        end else begin
                            check32("stream_adel", {31'h0, adel_out}, 32'h0);
                            check32("stream_inst", inst_out, mem_word(e));
                            exp_q.push_back(e + 32'd4);
                        end
                    end
                end else begin
                    idle_cyc++;
                    if (except || eret_en || redirect_en) idle_cyc = 0;
                    if (idle_cyc > 200) begin
                        checks++;
                        errors++;
                        $display("FAIL watchdog: no instruction delivered for %0d cycles", idle_cyc);
                        idle_cyc = 0;
                    end
                end
                hold_chk  = valid_out && !write && !(except || eret_en || redirect_en || flush);
                held_pc   = pc_out;
                held_inst = inst_out;
                held_adel = adel_out;
                out_pend  = imem_req && !imem_ack;
                pend_addr = imem_addr;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_pc"}, pc_out, 32'h0);
        check32({tag, "_inst"}, inst_out, 32'h0);
        check32({tag, "_valid"}, {31'h0, valid_out}, 32'h0);
        check32({tag, "_adel"}, {31'h0, adel_out}, 32'h0);
        check32({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] exp);
        if (ack_log.size() <= idx) begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d requests acknowledged, required entry %0d", name, ack_log.size(), idx);
        end else begin
            check32(name, ack_log[idx], exp);
        end
    endtask

    task automatic restart_after_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        ack_log.delete();
        mem_cnt  = 0;
        mem_lat  = lat_min;
        prev_req = 1'b0;
        prev_ack = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        write       = 1'b1;
        flush       = 1'b0;
        except      = 1'b0;
        eret_en     = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        epc_in      = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        check_reset_outputs("reset");

        // Zero-wait memory, decode always accepting
        lat_min = 0;
        lat_max = 0;
        restart_after_reset();
        #11;
        rst    = 1'b0;
        mon_en = 1'b1;
        drive_cycle(1'b0);
        check32("edge1_valid", {31'h0, valid_out}, 32'h0);
        check32("edge1_addr", imem_addr, RESET_PC);
        drive_cycle(1'b0);
        check32("edge2_valid", {31'h0, valid_out}, 32'h1);
        check32("edge2_pc", pc_out, RESET_PC);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0);
        check_log("seq_addr0", 0, 32'hBFC0_0000);
        check_log("seq_addr1", 1, 32'hBFC0_0004);
        check_log("seq_addr2", 2, 32'hBFC0_0008);

        // Three-cycle memory latency, no stalls
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 30; i++) drive_cycle(1'b0);

        // Random stalls, redirects and latencies
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) drive_cycle(1'b1);

        // Asynchronous reset in the middle of an outstanding request
        for (int i = 0; i < 50 && !(imem_req && !imem_ack); i++) drive_cycle(1'b1);
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        write       = 1'b1;
        flush       = 1'b0;
        except      = 1'b0;
        eret_en     = 1'b0;
        redirect_en = 1'b0;
        imem_ack    = 1'b0;
        restart_after_reset();
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) drive_cycle(1'b0);
        check_log("restart_addr", 0, RESET_PC);
        for (int i = 0; i < 600; i++) drive_cycle(1'b1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. Owns the architectural fetch PC and issues requests to instruction memory over a req/ack handshake. Presents a registered {pc, inst, valid} bundle that decode samples on every clock edge where write=1. Handles stall (write=0), flush, branch/jump redirect, exception entry and ERET, and drops any fetch made stale by a redirect.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch address after reset
EXC_VECTOR, 32'hBFC0_0380, fetch address on except

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; asynchronous, active-high
write  in  1  decode accepts the current bundle at this edge; 0 = stall, hold the bundle
flush  in  1  squash the presented bundle and any in-flight fetch
redirect_en  in  1  branch/jump taken
redirect_pc  in  32  branch/jump target
except  in  1  exception commit
eret_en  in  1  ERET commit
epc_in  in  32  ERET return address (CP0 EPC)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; word aligned
imem_ack  in  1  rdata valid this cycle; may arrive in the same cycle as req
imem_rdata  in  32  instruction word
pc_out  out  32  PC of the presented instruction
inst_out  out  32  instruction; 0 (NOP) when not valid
valid_out  out  1  bundle holds a real instruction
adel_out  out  1  presented PC is misaligned (address-error load on fetch)

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, state=IDLE, pc_out=0, inst_out=0, valid_out=0, adel_out=0, imem_req=0. Releasing rst mid-transaction starts cleanly from IDLE, and any late ack is ignored.
- States:
  - IDLE: entered for one cycle after reset. Goes to REQ.
  - REQ: imem_req=1 and imem_addr=fetch_pc, both held stable until ack.
  - FULL: an instruction is captured and waiting for write.
  - DROP: a stale request is outstanding. imem_req stays 1 until ack, and the data is discarded.
- Capture: in REQ with ack, the bundle register is loaded with {fetch_pc, imem_rdata, valid=1}, and fetch_pc advances by 4.
  - If write=1 in the same cycle, stay in REQ and issue the next request next cycle.
  - Otherwise go to FULL.
  - Throughput: 1 instruction/cycle with a zero-wait memory.
- Stall: while write=0, pc_out, inst_out, valid_out and adel_out hold their values. In FULL, no new request is issued.
- Consume: in FULL with write=1, the bundle becomes a bubble (valid=0, inst=0) unless a new capture occurs at the same edge. Next state is REQ.
- Redirect priority: except > eret_en > redirect_en.
  - New fetch_pc is EXC_VECTOR, epc_in or redirect_pc respectively.
  - If a request is un-acked this cycle, go to DROP; otherwise go to REQ.
  - The presented bundle is turned into a bubble at the edge.
  - Delay slot: the branch unit asserts redirect_en only after the delay-slot instruction has been accepted. This block does no delay-slot tracking.
- flush: bubbles the bundle and enters DROP if a request is outstanding. fetch_pc is unchanged unless a redirect is applied in the same cycle; flush is normally paired with except/eret_en.
- Misaligned fetch_pc (bits[1:0]!=0):
  - No imem request is issued.
  - The bundle is loaded directly with {fetch_pc, inst=0, valid=1, adel=1}.
  - The state goes to FULL and waits for a redirect (the exception will follow). fetch_pc does not advance.
- DROP with ack: go to REQ at the new fetch_pc. A further redirect while in DROP only updates fetch_pc.
- Simultaneous capture and redirect: the redirect wins and the captured data is dropped.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- Invariants:
  - valid_out=0 implies inst_out=0 and adel_out=0.
  - imem_addr never changes while imem_req=1 and ack=0.

Decomposition:
- Shared package: the state enum (IDLE, REQ, FULL, DROP), NOP constant 32'h0, default reset/exception vectors.
- One natural sub-module, if_next_pc: a combinational priority mux (except/eret/redirect/sequential) plus the alignment check.
- FSM and bundle registers stay in if_stage.

Test Plan:
- Reset, then zero-wait memory, write=1 -> imem_addr sequence BFC00000, BFC00004, BFC00008. valid_out=1 from the 2nd post-reset edge with pc_out tracking.
- Memory ack delayed 3 cycles -> imem_req and imem_addr held stable for 3 cycles, valid_out=0 meanwhile, and one bundle delivered.
- write=0 for 4 cycles with bundle pc=BFC00010 -> outputs frozen, no new request. write=1 -> next request to BFC00014.
- redirect_en with redirect_pc=80001000 while a request to BFC00008 is un-acked -> DROP, BFC00008 data never presented. Next request is 80001000.
- except and redirect_en in the same cycle -> fetch from BFC00380. eret_en with epc_in=80000204 -> fetch from 80000204.
- redirect_pc=80000002 -> no imem_req, bundle {80000002, 0, valid=1, adel=1}. rst asserted mid-request -> outputs 0 immediately (async), and fetch resumes at BFC00000.
